// File: rtl/coeff_loader_if.sv
// coeff_loader_if: start, byte stream, memory write port and load status.
// COEFF_CHECKSUM_EN adds the exp_sum / sum_err checksum pair.
interface coeff_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
`ifdef COEFF_CHECKSUM_EN
  logic [DATA_W+ADDR_W-1:0] exp_sum;
  logic                     sum_err;

  modport master (
    output start, s_valid, s_data, exp_sum,
    input  s_ready, we, waddr, wdata,
    input  busy, done, count, sum_err
  );

  modport slave (
    input  start, s_valid, s_data, exp_sum,
    output s_ready, we, waddr, wdata,
    output busy, done, count, sum_err
  );
`else
  modport master (
    output start, s_valid, s_data,
    input  s_ready, we, waddr, wdata,
    input  busy, done, count
  );

  modport slave (
    input  start, s_valid, s_data,
    output s_ready, we, waddr, wdata,
    output busy, done, count
  );
`endif
endinterface

// File: rtl/coeff_loader.sv
// coeff_loader: writes NUM_TAPS streamed bytes to coefficient memory 0..N-1.
// COEFF_CHECKSUM_EN adds a modulo accumulator checked against exp_sum.
module coeff_loader #(
  parameter int NUM_TAPS = 16,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4
) (
  input logic           clk,
  input logic           rst,
  coeff_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W:0] FULL =
    (ADDR_W + 1)'(NUM_TAPS);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   count_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              done_q;
  logic              in_load;
  logic              beat;
  logic              last;

  assign in_load = (state == LOAD);
  assign beat    = in_load && bus.s_valid;
  assign last    = beat && (idx == LAST);

  assign bus.s_ready = in_load;
  assign bus.busy    = in_load;
  assign bus.we      = we_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.done    = done_q;
  assign bus.count   = count_q;

  // load sequencer with one-cycle registered memory write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= LOAD;
            idx     <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (beat) begin
            we_q    <= 1'b1;
            waddr_q <= idx;
            wdata_q <= bus.s_data;
            if (count_q != FULL)
              count_q <= count_q + 1'b1;
            if (last) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COEFF_CHECKSUM_EN
  localparam int SUM_W = DATA_W + ADDR_W;

  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] acc_nxt;
  logic             err_q;

  assign acc_nxt     = acc + SUM_W'(bus.s_data);
  assign bus.sum_err = err_q;

  // running byte sum, compared once as the table completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      err_q <= 1'b0;
    end else if (!in_load && bus.start) begin
      acc   <= '0;
      err_q <= 1'b0;
    end else if (beat) begin
      acc <= acc_nxt;
      if (last)
        err_q <= (acc_nxt != bus.exp_sum);
    end
  end
`else
`endif

endmodule

// File: tb/tb_coeff_loader.sv
// tb_coeff_loader: randomized loads checked against a behavioural model.
// Build with COEFF_CHECKSUM_EN to also exercise the checksum compare.
module tb_coeff_loader;

  localparam int NT = 16;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  coeff_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  coeff_loader #(
    .NUM_TAPS(NT),
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model of one load
  bit          m_load;
  bit          m_done;
  bit          m_we;
  bit          m_err;
  int          m_idx;
  int          m_count;
  int          m_sum;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [DW+AW-1:0] exp_sum_v;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_q[$];

  // record every memory write the DUT performs
  always @(negedge clk)
    if (bus.we === 1'b1)
      obs_q.push_back({bus.waddr, bus.wdata});

  task automatic model_reset();
    m_load  = 0;
    m_done  = 0;
    m_we    = 0;
    m_err   = 0;
    m_idx   = 0;
    m_count = 0;
    m_sum   = 0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic drive(input bit st, input bit v,
                       input logic [DW-1:0] d);
    bus.start   = st;
    bus.s_valid = v;
    bus.s_data  = d;
`ifdef COEFF_CHECKSUM_EN
    bus.exp_sum = exp_sum_v;
`endif
    @(posedge clk);
    m_we = 0;
    if (m_load) begin
      if (v) begin
        exp_q.push_back({AW'(m_idx), d});
        m_we    = 1;
        m_waddr = AW'(m_idx);
        m_wdata = d;
        m_sum   = (m_sum + int'(d)) % (1 << (DW + AW));
        if (m_count < NT) m_count++;
        if (m_idx == NT - 1) begin
          m_load = 0;
          m_done = 1;
          m_err  = (m_sum != int'(exp_sum_v));
        end else begin
          m_idx++;
        end
      end
    end else if (st) begin
      m_load  = 1;
      m_done  = 0;
      m_count = 0;
      m_idx   = 0;
      m_sum   = 0;
      m_err   = 0;
    end
    @(negedge clk);
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
  endtask

  // dmode: 0 random bytes, 1 constant dval, 2 dval+beat
  task automatic run_load(input int vpct, input int spct,
                          input int dmode,
                          input logic [DW-1:0] dval);
    int guard;
    int k;
    bit v;
    bit st;
    logic [DW-1:0] d;
    guard = 0;
    k = 0;
    drive(1'b1, 1'b0, '0);
    while (m_load && guard < 400) begin
      v  = ($urandom % 100) < vpct;
      st = ($urandom % 100) < spct;
      case (dmode)
        0:       d = DW'($urandom);
        1:       d = dval;
        default: d = dval + DW'(k);
      endcase
      drive(st, v, d);
      if (v) k++;
      guard++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    exp_sum_v   = '0;
`ifdef COEFF_CHECKSUM_EN
    bus.exp_sum = '0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({bus.s_ready, bus.we, bus.busy, bus.done,
         bus.count, bus.waddr, bus.wdata} !== '0) begin
      bad++;
      $display("FAIL reset_vals got %b exp 0",
        {bus.s_ready, bus.we, bus.busy, bus.done,
         bus.count, bus.waddr, bus.wdata});
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, DW'($urandom));
      total++;
      if ({bus.s_ready, bus.we, bus.busy, bus.done} !== 4'b0
          || bus.count !== '0) begin
        bad++;
        $display("FAIL idle_quiet c%0d got %b cnt %0d exp 0",
          i, {bus.s_ready, bus.we, bus.busy, bus.done},
          bus.count);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    obs_q.delete();
    drive(1'b1, 1'b0, '0);
    total++;
    if ({bus.busy, bus.s_ready, bus.done} !== 3'b110
        || bus.count !== '0) begin
      bad++;
      $display("FAIL b2b_enter got %b cnt %0d exp 110 cnt 0",
        {bus.busy, bus.s_ready, bus.done}, bus.count);
    end
    for (int i = 0; i < NT; i++) begin
      drive(1'b0, 1'b1, DW'(i + 1));
      total++;
      if (bus.we !== 1'b1 || bus.waddr !== AW'(i)
          || bus.wdata !== DW'(i + 1)) begin
        bad++;
        $display("FAIL b2b_wr%0d got we%b a%0d d%h exp we1 a%0d d%h",
          i, bus.we, bus.waddr, bus.wdata, i, i + 1);
      end
    end
    total++;
    if (bus.s_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready_drop got %b exp 0", bus.s_ready);
    end
    drive(1'b0, 1'b1, DW'($urandom));
    total++;
    if ({bus.done, bus.we, bus.s_ready, bus.busy} !== 4'b1000
        || bus.count !== 5'(NT)) begin
      bad++;
      $display("FAIL b2b_done got %b cnt %0d exp 1000 cnt %0d",
        {bus.done, bus.we, bus.s_ready, bus.busy},
        bus.count, NT);
    end
    total++;
    if (obs_q.size() != NT) begin
      bad++;
      $display("FAIL b2b_nwr got %0d exp %0d", obs_q.size(), NT);
    end
  endtask

  task automatic test_gaps();
    int c;
    exp_q.delete();
    obs_q.delete();
    drive(1'b1, 1'b0, '0);
    c = 0;
    while (m_load && c < 100) begin
      drive(c == 6, c[0] == 1'b0, DW'($urandom));
      total++;
      if (bus.we !== m_we || bus.count !== 5'(m_count)
          || (m_we && (bus.waddr !== m_waddr
                       || bus.wdata !== m_wdata))) begin
        bad++;
        $display("FAIL gap_c%0d got we%b a%0d d%h n%0d exp we%b a%0d d%h n%0d",
          c, bus.we, bus.waddr, bus.wdata, bus.count,
          m_we, m_waddr, m_wdata, m_count);
      end
      c++;
    end
    drive(1'b0, 1'b0, '0);
    total++;
    if (obs_q.size() != NT || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL gap_end got nwr %0d done %b exp %0d 1",
        obs_q.size(), bus.done, NT);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL gap_wr%0d got %h exp %h",
          i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    obs_q.delete();
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++)
      drive(1'b0, 1'b1, DW'($urandom));
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.s_ready, bus.we, bus.busy, bus.done,
         bus.count, bus.waddr, bus.wdata} !== '0) begin
      bad++;
      $display("FAIL rst_async got %b exp 0",
        {bus.s_ready, bus.we, bus.busy, bus.done,
         bus.count, bus.waddr, bus.wdata});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    run_load(100, 0, 1, 8'hA5);
    drive(1'b0, 1'b0, '0);
    total++;
    if (bus.done !== 1'b1 || obs_q.size() != NT) begin
      bad++;
      $display("FAIL rst_reload got done %b nwr %0d exp 1 %0d",
        bus.done, obs_q.size(), NT);
    end
    for (int i = 0; i < NT; i++) begin
      total++;
      if (i >= obs_q.size()
          || obs_q[i] !== {AW'(i), 8'hA5}) begin
        bad++;
        $display("FAIL rst_wr%0d got %h exp %h",
          i, obs_q[i], {AW'(i), 8'hA5});
      end
    end
  endtask

  task automatic test_reload();
    exp_q.delete();
    obs_q.delete();
    drive(1'b1, 1'b1, 8'h33);
    total++;
    if ({bus.done, bus.busy, bus.we} !== 3'b010
        || bus.count !== '0) begin
      bad++;
      $display("FAIL reload_start got %b cnt %0d exp 010 cnt 0",
        {bus.done, bus.busy, bus.we}, bus.count);
    end
    run_load(70, 10, 1, 8'hFF);
    drive(1'b0, 1'b0, '0);
    total++;
    if (bus.done !== 1'b1 || bus.count !== 5'(NT)
        || obs_q.size() != NT) begin
      bad++;
      $display("FAIL reload_end got done %b cnt %0d nwr %0d",
        bus.done, bus.count, obs_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]
          || obs_q[i][DW-1:0] !== 8'hFF) begin
        bad++;
        $display("FAIL reload_wr%0d got %h exp %h",
          i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      exp_q.delete();
      obs_q.delete();
      run_load(20 + 20 * r, 15, 0, '0);
      drive(1'b0, 1'b1, DW'($urandom));
      total++;
      if (bus.done !== m_done || bus.count !== 5'(m_count)
          || obs_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL rnd%0d got done %b cnt %0d nwr %0d exp %b %0d %0d",
          r, bus.done, bus.count, obs_q.size(),
          m_done, m_count, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL rnd%0d_wr%0d got %h exp %h",
            r, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

`ifdef COEFF_CHECKSUM_EN
  task automatic test_checksum();
    exp_sum_v = 12'h088;
    run_load(100, 0, 2, 8'h01);
    total++;
    if (bus.done !== 1'b1 || bus.sum_err !== 1'b0) begin
      bad++;
      $display("FAIL sum_ok got done %b err %b exp 1 0",
        bus.done, bus.sum_err);
    end
    exp_sum_v = 12'h089;
    run_load(60, 0, 2, 8'h01);
    total++;
    if (bus.done !== 1'b1 || bus.sum_err !== 1'b1
        || m_err !== 1'b1) begin
      bad++;
      $display("FAIL sum_bad got done %b err %b exp 1 1",
        bus.done, bus.sum_err);
    end
    drive(1'b1, 1'b0, '0);
    total++;
    if (bus.sum_err !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL sum_clr got err %b done %b exp 0 0",
        bus.sum_err, bus.done);
    end
    run_load(100, 0, 0, '0);
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    test_reload();
    test_random();
`ifdef COEFF_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
